isp_vid_gen: RTL and testbench

Raw Bayer video source for the ISP pipeline. It generates href/vsync/raw frames with programmable blanking and one of four test patterns, and drives the `in_href`/`in_vsync`/`in_raw` inputs of the ISP top. It is the transmitting end of the ISP pixel-stream interface and stands in for a sensor during bring-up and verification.

---
 rtl/isp_vid_gen.sv | 206 ++++++++++++++++++++
 tb/tb_isp_vid_gen.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_vid_gen.sv
// isp_vid_gen: raw Bayer test-pattern video source.
// Produces vsync / href / raw frames with programmable blanking and one of
// four patterns. It stands in for an image sensor ahead of the ISP top.
// Every output is registered from the next-cycle state, so the output seen
// in a cycle always matches the FSM position of that same cycle.
module isp_vid_gen #(
    parameter int BITS    = 8,
    parameter int WIDTH   = 256,
    parameter int HEIGHT  = 10,
    parameter int BAYER   = 0,
    parameter int VSYNC_W = 8,
    parameter int VFP     = 8,
    parameter int HBLANK  = 16,
    parameter int VBP     = 8
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [1:0]      pattern,
    input  logic [BITS-1:0] flat_value,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_raw,
    output logic            busy,
    output logic            frame_done,
    output logic [15:0]     frame_cnt
);

    localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int M1   = (VSYNC_W > VFP) ? VSYNC_W : VFP;
    localparam int M2   = (HBLANK  > VBP) ? HBLANK  : VBP;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] VSYNC_LAST  = CW'(VSYNC_W - 1);
    localparam logic [CW-1:0] VFP_LAST    = CW'(VFP - 1);
    localparam logic [CW-1:0] HBLANK_LAST = CW'(HBLANK - 1);
    localparam logic [CW-1:0] VBP_LAST    = CW'(VBP - 1);
    localparam logic [XW-1:0] X_LAST      = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);

    localparam logic [BITS-1:0] PIX_MAX = {BITS{1'b1}};
    localparam logic [BITS-1:0] PIX_MID = {1'b1, {(BITS-1){1'b0}}};
    // In all four CFA orders the R site index equals the order code and the
    // B site is the diagonally opposite one.
    localparam logic [1:0]      R_SITE  = 2'(BAYER);
    localparam logic [1:0]      B_SITE  = ~R_SITE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VFP,
        S_LINE,
        S_HBLK,
        S_VBP
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [XW-1:0]   x, x_nx;
    logic [YW-1:0]   y, y_nx;
    logic [1:0]      pat_q, pat_nx;
    logic [BITS-1:0] flat_q, flat_nx;
    logic            frame_end;
    logic            href_p0;
    logic            vsync_p0;
    logic [BITS-1:0] raw_p0;
    logic            busy_p0;
    logic            done_p0;

    function automatic logic [BITS-1:0] pix_value(
        input logic [1:0]      pat,
        input logic [BITS-1:0] flat,
        input logic [XW-1:0]   px,
        input logic [YW-1:0]   py
    );
        logic [BITS-1:0] v;
        logic [1:0]      site;
        site = {py[0], px[0]};
        case (pat)
            2'd0: v = BITS'(int'(px) + int'(py));
            2'd1: begin
                if (site == R_SITE)      v = PIX_MAX;
                else if (site == B_SITE) v = '0;
                else                     v = PIX_MID;
            end
            2'd2: v = flat;
            default: v = (((int'(px) ^ int'(py)) & 8) != 0) ? PIX_MAX : '0;
        endcase
        return v;
    endfunction

    // Next-state, counters, pattern latch and next-cycle output values.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        x_nx      = x;
        y_nx      = y;
        pat_nx    = pat_q;
        flat_nx   = flat_q;
        frame_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nx = S_VSYNC;
                    cnt_nx   = '0;
                    pat_nx   = pattern;
                    flat_nx  = flat_value;
                end
            end
            S_VSYNC: begin
                if (cnt == VSYNC_LAST) begin
                    state_nx = S_VFP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_VFP: begin
                if (cnt == VFP_LAST) begin
                    state_nx = S_LINE;
                    cnt_nx   = '0;
                    x_nx     = '0;
                    y_nx     = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_LINE: begin
                if (x == X_LAST) begin
                    cnt_nx   = '0;
                    state_nx = (y == Y_LAST) ? S_VBP : S_HBLK;
                end else begin
                    x_nx = x + 1'b1;
                end
            end
            S_HBLK: begin
                if (cnt == HBLANK_LAST) begin
                    state_nx = S_LINE;
                    cnt_nx   = '0;
                    x_nx     = '0;
                    y_nx     = y + 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_VBP: begin
                if (cnt == VBP_LAST) begin
                    frame_end = 1'b1;
                    cnt_nx    = '0;
                    if (enable) begin
                        state_nx = S_VSYNC;
                        pat_nx   = pattern;
                        flat_nx  = flat_value;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        href_p0  = (state_nx == S_LINE);
        vsync_p0 = (state_nx == S_VSYNC);
        busy_p0  = (state_nx != S_IDLE);
        done_p0  = (state_nx == S_VBP) && (cnt_nx == VBP_LAST);
        raw_p0   = href_p0 ? pix_value(pat_q, flat_q, x_nx, y_nx) : '0;
    end

    // FSM state, position counters and registered outputs.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            x          <= '0;
            y          <= '0;
            out_href   <= 1'b0;
            out_vsync  <= 1'b0;
            out_raw    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            x          <= x_nx;
            y          <= y_nx;
            out_href   <= href_p0;
            out_vsync  <= vsync_p0;
            out_raw    <= raw_p0;
            busy       <= busy_p0;
            frame_done <= done_p0;
            if (frame_end) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Pattern selection held for the whole frame; only read while href is high.
    always_ff @(posedge pclk) begin
        pat_q  <= pat_nx;
        flat_q <= flat_nx;
    end

endmodule

// File: tb/tb_isp_vid_gen.sv
// Testbench for isp_vid_gen: frame-level reference model plus pixel tables.
module tb_isp_vid_gen;

    localparam int W   = 256;
    localparam int H   = 10;
    localparam int VW  = 8;
    localparam int VFP = 8;
    localparam int HB  = 16;
    localparam int VBP = 8;
    localparam int LP  = W + HB;
    localparam int T0  = VW + VFP;
    localparam int P   = T0 + H * W + (H - 1) * HB + VBP;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [7:0]  flat_value = 8'd0;

    logic        out_href, out_vsync, busy, frame_done;
    logic [7:0]  out_raw;
    logic [15:0] frame_cnt;
    logic        b3_href, b3_vsync, b3_busy, b3_done;
    logic [7:0]  b3_raw;
    logic [15:0] b3_cnt;

    isp_vid_gen #(.BITS(8), .WIDTH(W), .HEIGHT(H), .BAYER(0), .VSYNC_W(VW),
                  .VFP(VFP), .HBLANK(HB), .VBP(VBP)) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .pattern(pattern),
        .flat_value(flat_value), .out_href(out_href), .out_vsync(out_vsync),
        .out_raw(out_raw), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt));

    isp_vid_gen #(.BITS(8), .WIDTH(W), .HEIGHT(H), .BAYER(3), .VSYNC_W(VW),
                  .VFP(VFP), .HBLANK(HB), .VBP(VBP)) u_b3 (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .pattern(pattern),
        .flat_value(flat_value), .out_href(b3_href), .out_vsync(b3_vsync),
        .out_raw(b3_raw), .busy(b3_busy), .frame_done(b3_done),
        .frame_cnt(b3_cnt));

    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- reference model (frame-position arithmetic) ----------
    function automatic logic [7:0] ref_pix(int x, int y, int pat, int flat, int bay);
        string ord;
        byte   ch;
        case (pat)
            0: return 8'((x + y) % 256);
            1: begin
                case (bay)
                    0: ord = "RGGB";
                    1: ord = "GRBG";
                    2: ord = "GBRG";
                    default: ord = "BGGR";
                endcase
                ch = ord[(y % 2) * 2 + (x % 2)];
                if (ch == "R") return 8'd255;
                if (ch == "G") return 8'd128;
                return 8'd0;
            end
            2: return 8'(flat);
            default: return (((x / 8) + (y / 8)) % 2 == 1) ? 8'd255 : 8'd0;
        endcase
    endfunction

    // {href, vsync, raw[7:0], busy, frame_done} expected at frame cycle c
    function automatic logic [11:0] ref_out(bit act, int c, int pat, int flat, int bay);
        int t, x, y;
        bit hr, vs;
        logic [7:0] r;
        if (!act) return 12'd0;
        vs = (c < VW);
        t  = c - T0;
        hr = 1'b0;
        x  = 0;
        y  = 0;
        if (t >= 0) begin
            x  = t % LP;
            y  = t / LP;
            hr = (y < H) && (x < W);
        end
        r = hr ? ref_pix(x, y, pat, flat, bay) : 8'd0;
        return {hr, vs, r, 1'b1, (c == P - 1)};
    endfunction

    bit          m_act = 1'b0;
    int          m_c = 0;
    int          m_pat = 0;
    int          m_flat = 0;
    logic [15:0] m_cnt = 16'd0;
    bit          load_wrap = 1'b0;
    bit          chk_en = 1'b1;

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0;
            m_c   <= 0;
            m_cnt <= 16'd0;
        end else begin
            if (load_wrap) m_cnt <= 16'hFFFF;
            else if (m_act && m_c == P - 1) m_cnt <= m_cnt + 16'd1;
            if (!m_act) begin
                if (enable) begin
                    m_act  <= 1'b1;
                    m_c    <= 0;
                    m_pat  <= int'(pattern);
                    m_flat <= int'(flat_value);
                end
            end else if (m_c == P - 1) begin
                if (enable) begin
                    m_c    <= 0;
                    m_pat  <= int'(pattern);
                    m_flat <= int'(flat_value);
                end else begin
                    m_act <= 1'b0;
                end
            end else begin
                m_c <= m_c + 1;
            end
        end
    end

    // ---------------- monitor ---------------------------------------------
    int cyc = 0;
    int vs_q[$];
    int vs_hi_total = 0, href_total = 0, busy_total = 0, fd_total = 0;
    int fd_cyc = 0, first_href = -1, cur_line = -1, cx = 0;
    int blank_nz = 0, overlap = 0;
    bit prev_vs = 1'b0, prev_hr = 1'b0;
    int pix[H][W];
    int pix3[H][W];
    int stream_err = 0, err_cyc = 0;
    logic [11:0] err_g, err_e;

    always @(negedge pclk) begin
        cyc++;
        if (out_vsync && !prev_vs) begin
            vs_q.push_back(cyc);
            cur_line   = -1;
            first_href = -1;
        end
        if (out_vsync) vs_hi_total++;
        if (busy) busy_total++;
        if (out_vsync && out_href) overlap++;
        if ((!out_href && out_raw != 8'd0) || (!b3_href && b3_raw != 8'd0)) blank_nz++;
        if (out_href) begin
            href_total++;
            if (!prev_hr) begin
                cur_line++;
                cx = 0;
                if (first_href < 0) first_href = cyc;
            end
            if (cur_line >= 0 && cur_line < H && cx < W) begin
                pix[cur_line][cx]  = int'(out_raw);
                pix3[cur_line][cx] = int'(b3_raw);
            end
            cx++;
        end
        if (frame_done) begin
            fd_total++;
            fd_cyc = cyc;
        end
        prev_vs = out_vsync;
        prev_hr = out_href;
    end

    always @(negedge pclk) begin
        logic [11:0] e, e3, g, g3;
        e  = ref_out(m_act, m_c, m_pat, m_flat, 0);
        e3 = ref_out(m_act, m_c, m_pat, m_flat, 3);
        g  = {out_href, out_vsync, out_raw, busy, frame_done};
        g3 = {b3_href, b3_vsync, b3_raw, b3_busy, b3_done};
        if (chk_en && (g !== e || g3 !== e3 || frame_cnt !== m_cnt)) begin
            if (stream_err == 0) begin
                err_cyc = cyc;
                err_g   = g;
                err_e   = e;
            end
            stream_err++;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic wait_fd(input int target, input string nm);
        int k = 0;
        while (fd_total < target && k < 4 * P) begin
            @(negedge pclk);
            pattern    = 2'($urandom);
            flat_value = 8'($urandom);
            k++;
        end
        chk(nm, fd_total, target);
    endtask

    task automatic run_frame(input int pat, input int flat);
        int target;
        target = fd_total + 1;
        @(negedge pclk);
        pattern    = 2'(pat);
        flat_value = 8'(flat);
        enable     = 1'b1;
        @(negedge pclk);
        enable = 1'b0;
        wait_fd(target, $sformatf("frame_p%0d_timeout", pat));
        repeat (20) @(negedge pclk);
    endtask

    typedef struct {
        int pat;
        int flat;
        int inst;
        int x;
        int y;
        int exp;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int vsq0, href0, vshi0, busy0, fd0, bad, cur_pat, cur_flat, got, k;

        tbl[0]  = '{0, 0, 0, 0, 1, 1};
        tbl[1]  = '{0, 0, 0, 255, 1, 0};
        tbl[2]  = '{0, 0, 0, 5, 3, 8};
        tbl[3]  = '{0, 0, 0, 200, 9, 209};
        tbl[4]  = '{1, 0, 0, 0, 0, 255};
        tbl[5]  = '{1, 0, 0, 1, 0, 128};
        tbl[6]  = '{1, 0, 0, 0, 1, 128};
        tbl[7]  = '{1, 0, 0, 1, 1, 0};
        tbl[8]  = '{1, 0, 0, 2, 0, 255};
        tbl[9]  = '{1, 0, 1, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 1, 0, 128};
        tbl[11] = '{1, 0, 1, 0, 1, 128};
        tbl[12] = '{1, 0, 1, 1, 1, 255};
        tbl[13] = '{2, 'h5A, 0, 3, 4, 'h5A};
        tbl[14] = '{2, 'h5A, 0, 255, 9, 'h5A};
        tbl[15] = '{3, 0, 0, 7, 0, 0};
        tbl[16] = '{3, 0, 0, 8, 0, 255};
        tbl[17] = '{3, 0, 0, 8, 8, 0};
        tbl[18] = '{3, 0, 0, 0, 8, 255};

        // reset and idle
        rst_n = 1'b0;
        repeat (3) @(negedge pclk);
        chk("reset_outs", {out_href, out_vsync, out_raw, busy, frame_done, frame_cnt}, 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge pclk);
            if ({out_href, out_vsync, out_raw, busy, frame_done, frame_cnt} != 0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // single frame, ramp pattern
        vsq0  = vs_q.size();
        href0 = href_total;
        vshi0 = vs_hi_total;
        busy0 = busy_total;
        run_frame(0, 0);
        chk("vsync_cycles", vs_hi_total - vshi0, VW);
        chk("href_cycles", href_total - href0, 2560);
        chk("busy_cycles", busy_total - busy0, 2728);
        chk("line_count", cur_line + 1, H);
        if (vs_q.size() > vsq0) begin
            chk("first_href_ofs", first_href - vs_q[$], 16);
            chk("done_ofs", fd_cyc - vs_q[$], 2727);
        end
        chk("frame_cnt_1", frame_cnt, 1);
        chk("busy_after", busy, 0);
        repeat (100) @(negedge pclk);
        chk("single_vsync", vs_q.size() - vsq0, 1);

        // pixel tables
        cur_pat  = 0;
        cur_flat = 0;
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].pat != cur_pat || tbl[i].flat != cur_flat) begin
                run_frame(tbl[i].pat, tbl[i].flat);
                cur_pat  = tbl[i].pat;
                cur_flat = tbl[i].flat;
            end
            got = (tbl[i].inst != 0) ? pix3[tbl[i].y][tbl[i].x] : pix[tbl[i].y][tbl[i].x];
            chk($sformatf("vec%0d_p%0d_b%0d_x%0d_y%0d", i, tbl[i].pat, tbl[i].inst * 3,
                          tbl[i].x, tbl[i].y), got, tbl[i].exp);
        end

        // continuous mode with random mid-frame pattern changes, enable dropped in frame 3
        vsq0 = vs_q.size();
        fd0  = fd_total;
        @(negedge pclk);
        pattern    = 2'($urandom);
        flat_value = 8'($urandom);
        enable     = 1'b1;
        k = 0;
        while (fd_total < fd0 + 2 && k < 3 * P) begin
            @(negedge pclk);
            pattern    = 2'($urandom);
            flat_value = 8'($urandom);
            k++;
        end
        repeat (1000) begin
            @(negedge pclk);
            pattern    = 2'($urandom);
            flat_value = 8'($urandom);
        end
        enable = 1'b0;
        wait_fd(fd0 + 3, "cont_timeout");
        repeat (50) @(negedge pclk);
        chk("cont_vsync_rises", vs_q.size() - vsq0, 3);
        if (vs_q.size() >= vsq0 + 3) begin
            chk("cont_rise1", vs_q[vsq0 + 1] - vs_q[vsq0], 2728);
            chk("cont_rise2", vs_q[vsq0 + 2] - vs_q[vsq0], 5456);
        end
        chk("cont_frame_cnt", frame_cnt, 7);
        chk("cont_idle_busy", busy, 0);

        // reset asserted in the middle of a line
        @(negedge pclk);
        enable = 1'b1;
        @(negedge pclk);
        enable = 1'b0;
        repeat (300) @(negedge pclk);
        chk("pre_reset_href", out_href, 1);
        @(posedge pclk);
        #2 rst_n = 1'b0;
        #1 chk("reset_midline", {out_href, out_vsync, out_raw, busy, frame_done, frame_cnt}, 0);
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        vsq0  = vs_q.size();
        href0 = href_total;
        run_frame(3, 0);
        chk("restart_href", href_total - href0, 2560);
        if (vs_q.size() > vsq0) chk("restart_done_ofs", fd_cyc - vs_q[$], 2727);
        chk("restart_frame_cnt", frame_cnt, 1);

        // frame counter wrap from 0xFFFF
        @(negedge pclk);
        chk_en = 1'b0;
        @(negedge pclk);
        force dut.frame_cnt = 16'hFFFF;
        load_wrap = 1'b1;
        @(posedge pclk);
        #1 release dut.frame_cnt;
        load_wrap = 1'b0;
        @(negedge pclk);
        chk("wrap_preload", frame_cnt, 16'hFFFF);
        @(negedge pclk);
        chk_en = 1'b1;
        run_frame(0, 0);
        chk("wrap_frame_cnt", frame_cnt, 0);

        // whole-run properties
        chk("blank_raw_zero", blank_nz, 0);
        chk("vsync_href_overlap", overlap, 0);
        chk("stream_vs_model", stream_err, 0);
        if (stream_err != 0)
            $display("first stream difference at cycle %0d: dut %h model %h", err_cyc, err_g, err_e);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
